// File: rtl/nios_onchip_mem_arbiter_pkg.sv
// rtl/nios_onchip_mem_arbiter_pkg.sv - shared constants and read-tag type for the on-chip RAM arbiter
// Purpose : port identifiers, tag field widths and the read-return tag carried
//           through the latency pipeline.
// Contents: PORT_NIOS, PORT_PCI, TAG_PORT_W, MAX_READ_LATENCY, rd_tag_t, make_tag()
package nios_onchip_mem_arbiter_pkg;

   localparam int PORT_NIOS        = 0;
   localparam int PORT_PCI         = 1;
   localparam int TAG_PORT_W       = 1;
   localparam int MAX_READ_LATENCY = 4;

   typedef struct packed {
      logic                  valid;
      logic [TAG_PORT_W-1:0] port;
   } rd_tag_t;

   function automatic rd_tag_t make_tag(input logic valid, input logic [TAG_PORT_W-1:0] port);
      rd_tag_t t;
      t.valid = valid;
      t.port  = port;
      return t;
   endfunction

endpackage

// File: rtl/nios_rr_arb2.sv
// rtl/nios_rr_arb2.sv - two-way round-robin arbitration core
// Purpose : combinational one-hot grant from req and the registered last winner.
// Ports   : clk, reset (sync, active-high), en (grant enable),
//           req[1:0] (requests), gnt[1:0] (one-hot grant, zero when idle or disabled)
module nios_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // Starts at 1 so port 0 wins the first contention after reset.
   logic last_gnt;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Pointer moves only on cycles that actually grant somebody.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt <= 1'b1;
      end else if (|gnt) begin
         last_gnt <= gnt[1];
      end
   end

endmodule

// File: rtl/nios_onchip_mem_arbiter.sv
// rtl/nios_onchip_mem_arbiter.sv - round-robin sharing of one on-chip RAM between two Avalon-MM masters
// Purpose : port 0 (Nios data master) and port 1 (PCI bridge master) share a
//           single-port RAM, one access per cycle, pipelined reads.
// Ports   : clk, reset (sync, active-high)
//           m0_* / m1_* : address, byteenable, read, write, writedata in;
//                         waitrequest, readdata, readdatavalid out
//           ram_*       : address, byteenable, chipselect, write, writedata, clken out;
//                         readdata in
module nios_onchip_mem_arbiter
   import nios_onchip_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset,

   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,

   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,

   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_clken,
   input  logic [DATA_W-1:0]   ram_readdata
);

   localparam int BE_W      = DATA_W / 8;
   localparam int TAG_DEPTH = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                              (READ_LATENCY < 1)                ? 1 : READ_LATENCY;

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              any_acc;

   logic [ADDR_W-1:0] sel_address;
   logic [BE_W-1:0]   sel_byteenable;
   logic [DATA_W-1:0] sel_writedata;
   logic              sel_read;
   logic              sel_write;

   logic [ADDR_W-1:0] hold_address;
   logic [BE_W-1:0]   hold_byteenable;
   logic [DATA_W-1:0] hold_writedata;

   rd_tag_t           tag_pipe [TAG_DEPTH];
   rd_tag_t           tag_tail;
   logic              issue_read;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   // No grants while reset is high, so waitrequest simply follows req then.
   nios_rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .reset (reset),
      .en    (~reset),
      .req   (req),
      .gnt   (gnt)
   );

   assign m0_waitrequest = req[0] & ~gnt[0];
   assign m1_waitrequest = req[1] & ~gnt[1];

   // gnt is only ever set for a requesting port, so any grant is an acceptance.
   assign any_acc = |(req & gnt);

   always_comb begin
      sel_address    = m0_address;
      sel_byteenable = m0_byteenable;
      sel_writedata  = m0_writedata;
      sel_read       = m0_read;
      sel_write      = m0_write;
      if (gnt[1]) begin
         sel_address    = m1_address;
         sel_byteenable = m1_byteenable;
         sel_writedata  = m1_writedata;
         sel_read       = m1_read;
         sel_write      = m1_write;
      end
   end

   // RAM address/data keep the last accepted values on idle cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_address    <= '0;
         hold_byteenable <= '0;
         hold_writedata  <= '0;
      end else if (any_acc) begin
         hold_address    <= sel_address;
         hold_byteenable <= sel_byteenable;
         hold_writedata  <= sel_writedata;
      end
   end

   assign ram_address    = any_acc ? sel_address    : hold_address;
   assign ram_byteenable = any_acc ? sel_byteenable : hold_byteenable;
   assign ram_writedata  = any_acc ? sel_writedata  : hold_writedata;
   assign ram_chipselect = any_acc;
   assign ram_write      = any_acc & sel_write;
   assign ram_clken      = 1'b1;

   // Read+write together is a write: no return tag for it.
   assign issue_read = any_acc & sel_read & ~sel_write;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAG_DEPTH; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         tag_pipe[0] <= make_tag(issue_read, gnt[1]);
         for (int i = 1; i < TAG_DEPTH; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   assign tag_tail = tag_pipe[TAG_DEPTH-1];

   // Gating with reset drops the tag already at the tail when reset lands mid-read.
   assign m0_readdatavalid = tag_tail.valid & ~reset & (tag_tail.port == TAG_PORT_W'(PORT_NIOS));
   assign m1_readdatavalid = tag_tail.valid & ~reset & (tag_tail.port == TAG_PORT_W'(PORT_PCI));

   assign m0_readdata = ram_readdata;
   assign m1_readdata = ram_readdata;

endmodule

// File: tb/tb_nios_onchip_mem_arbiter.sv
// tb/tb_nios_onchip_mem_arbiter.sv - self-checking bench for nios_onchip_mem_arbiter
module tb_nios_onchip_mem_arbiter;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int RL     = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [3:0]        m0_byteenable, m1_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] ram_address;
   logic [3:0]        ram_byteenable;
   logic              ram_chipselect, ram_write, ram_clken;
   logic [DATA_W-1:0] ram_writedata, ram_readdata;

   nios_onchip_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
   );

   // RAM: registered address, unregistered output, byte-enabled writes.
   logic [DATA_W-1:0] ram_mem [4096];
   logic [ADDR_W-1:0] ram_addr_q = '0;
   always @(posedge clk) begin
      if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end
         end
         ram_addr_q <= ram_address;
      end
   end
   assign ram_readdata = ram_mem[ram_addr_q];

   // Reference model: shadow memory, winner pointer, per-port expected returns.
   typedef struct { logic [31:0] d; int due; } exp_t;
   logic [31:0] shadow [4096];
   exp_t        q0[$];
   exp_t        q1[$];
   int          m_last;
   int          cyc;
   int          wait_run [2];
   logic [31:0] last_rd  [2];

   logic        p_rd [2];
   logic        p_wr [2];
   logic [11:0] p_addr [2];
   logic [3:0]  p_be [2];
   logic [31:0] p_wd [2];
   logic        acc_flag [2];
   logic        rand_mode;

   int n_vec = 0;
   int n_err = 0;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic apply();
      m0_read = p_rd[0]; m0_write = p_wr[0]; m0_address = p_addr[0];
      m0_byteenable = p_be[0]; m0_writedata = p_wd[0];
      m1_read = p_rd[1]; m1_write = p_wr[1]; m1_address = p_addr[1];
      m1_byteenable = p_be[1]; m1_writedata = p_wd[1];
   endtask

   task automatic set_req(input int p, input logic rd, input logic wr, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] d);
      p_rd[p] = rd; p_wr[p] = wr; p_addr[p] = a; p_be[p] = be; p_wd[p] = d;
      apply();
   endtask

   task automatic rand_req(input int p);
      int kind;
      kind = int'($urandom_range(0, 4));
      p_rd[p]   = (kind <= 1) || (kind == 4);
      p_wr[p]   = (kind >= 2);
      p_addr[p] = ($urandom_range(0, 5) == 0) ? 12'hFFF : 12'($urandom_range(0, 7));
      p_be[p]   = 4'($urandom_range(0, 15));
      p_wd[p]   = $urandom;
   endtask

   task automatic check_return(input int p, input logic v, input logic [31:0] d);
      logic exp_v;
      exp_t e;
      exp_v = 1'b0;
      if (p == 0 && q0.size() > 0) begin e = q0[0]; exp_v = (e.due == cyc); end
      if (p == 1 && q1.size() > 0) begin e = q1[0]; exp_v = (e.due == cyc); end
      if (reset) exp_v = 1'b0;
      expect_eq(p == 0 ? "rdv0" : "rdv1", 32'(v), 32'(exp_v));
      if (exp_v) begin
         if (v) expect_eq(p == 0 ? "rdata0" : "rdata1", d, e.d);
         if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (v) last_rd[p] = d;
   endtask

   task automatic step();
      logic [1:0] r, g;
      logic       wt;
      @(negedge clk);
      cyc++;
      r = {p_rd[1] | p_wr[1], p_rd[0] | p_wr[0]};
      if (reset)          g = 2'b00;
      else if (r == 2'b11) g = (m_last == 1) ? 2'b01 : 2'b10;
      else                g = r;
      expect_eq("wait0", 32'(m0_waitrequest), 32'(r[0] & ~g[0]));
      expect_eq("wait1", 32'(m1_waitrequest), 32'(r[1] & ~g[1]));
      expect_eq("chipselect", 32'(ram_chipselect), 32'(|g));
      expect_eq("ram_write", 32'(ram_write), 32'((g[0] & p_wr[0]) | (g[1] & p_wr[1])));
      expect_eq("clken", 32'(ram_clken), 32'd1);
      check_return(0, m0_readdatavalid, m0_readdata);
      check_return(1, m1_readdatavalid, m1_readdata);
      if (reset) begin
         q0.delete(); q1.delete();
         m_last = 1;
      end
      for (int i = 0; i < 2; i++) begin
         wt = (i == 0) ? m0_waitrequest : m1_waitrequest;
         if (r[i] && wt && !reset) begin
            wait_run[i]++;
            expect_eq("starve", 32'(wait_run[i] <= 1), 32'd1);
         end else begin
            wait_run[i] = 0;
         end
         acc_flag[i] = g[i];
         if (g[i]) begin
            expect_eq("ram_address", 32'(ram_address), 32'(p_addr[i]));
            if (p_wr[i]) begin
               for (int b = 0; b < 4; b++) begin
                  if (p_be[i][b]) shadow[p_addr[i]][8*b +: 8] = p_wd[i][8*b +: 8];
               end
            end else if (i == 0) begin
               q0.push_back('{d: shadow[p_addr[i]], due: cyc + RL});
            end else begin
               q1.push_back('{d: shadow[p_addr[i]], due: cyc + RL});
            end
            m_last = i;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (acc_flag[i]) begin p_rd[i] = 1'b0; p_wr[i] = 1'b0; end
         if (rand_mode && !(p_rd[i] | p_wr[i]) && $urandom_range(0, 3) != 0) rand_req(i);
      end
      apply();
   endtask

   task automatic run_idle(input int maxc);
      int k = 0;
      while ((p_rd[0] | p_wr[0] | p_rd[1] | p_wr[1]) && k < maxc) begin
         step();
         k++;
      end
      if (p_rd[0] | p_wr[0] | p_rd[1] | p_wr[1]) begin
         expect_eq("timeout", 32'd0, 32'd1);
         for (int i = 0; i < 2; i++) begin p_rd[i] = 1'b0; p_wr[i] = 1'b0; end
         apply();
      end
   endtask

   task automatic drain(input int n);
      repeat (n) step();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin ram_mem[i] = '0; shadow[i] = '0; end
      for (int i = 0; i < 2; i++) begin
         p_rd[i] = 0; p_wr[i] = 0; p_addr[i] = '0; p_be[i] = '0; p_wd[i] = '0;
         wait_run[i] = 0; last_rd[i] = '0; acc_flag[i] = 0;
      end
      rand_mode = 1'b0; m_last = 1; cyc = 0;
      reset = 1'b1;
      apply();
      drain(2);
      // waitrequest follows req during reset
      set_req(1, 1, 0, 12'h001, 4'hF, 0);
      drain(1);
      reset = 1'b0;
      run_idle(4);
      drain(2);

      // 1: write then read back on port 0
      set_req(0, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF); run_idle(4);
      set_req(0, 1, 0, 12'h010, 4'hF, 0);            run_idle(4);
      drain(2);
      expect_eq("t1_data", last_rd[0], 32'hDEADBEEF);

      // 2: both ports read every cycle
      for (int k = 0; k < 4; k++) begin
         set_req(0, 1, 0, 12'(k), 4'hF, 0);
         set_req(1, 1, 0, 12'h010 - 12'(k), 4'hF, 0);
         run_idle(6);
      end
      drain(2);

      // 3: byte write at the top address
      set_req(0, 0, 1, 12'hFFF, 4'hF, 32'h11223344); run_idle(4);
      set_req(1, 0, 1, 12'hFFF, 4'b0001, 32'h000000AA); run_idle(4);
      set_req(0, 1, 0, 12'hFFF, 4'hF, 0); run_idle(4);
      drain(2);
      expect_eq("t3_data", last_rd[0], 32'h112233AA);

      // 4: conflict, port 0 write wins, port 1 read returns new data
      set_req(1, 1, 0, 12'h021, 4'hF, 0); run_idle(4);
      drain(2);
      set_req(0, 0, 1, 12'h020, 4'hF, 32'h5);
      set_req(1, 1, 0, 12'h020, 4'hF, 0);
      run_idle(6);
      drain(2);
      expect_eq("t4_data", last_rd[1], 32'h5);

      // 5: reset while a read is in flight
      set_req(1, 0, 1, 12'h040, 4'hF, 32'hCAFE0001); run_idle(4);
      set_req(0, 1, 0, 12'h010, 4'hF, 0); run_idle(4);
      reset = 1'b1;
      drain(1);
      reset = 1'b0;
      drain(2);
      set_req(0, 1, 0, 12'h040, 4'hF, 0);
      set_req(1, 1, 0, 12'h020, 4'hF, 0);
      run_idle(6);
      drain(2);

      // 6: read and write together is a write
      set_req(0, 1, 1, 12'h030, 4'hF, 32'h77); run_idle(4);
      drain(2);
      set_req(0, 1, 0, 12'h030, 4'hF, 0); run_idle(4);
      drain(2);
      expect_eq("t6_data", last_rd[0], 32'h77);

      // random traffic with occasional reset pulses
      rand_mode = 1'b1;
      repeat (600) begin
         reset = ($urandom_range(0, 59) == 0);
         step();
      end
      reset = 1'b0;
      rand_mode = 1'b0;
      run_idle(10);
      drain(RL + 2);
      expect_eq("q_empty", 32'(q0.size() + q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
